dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Each transaction walks IDLE -> ACCESS -> RESP, so it takes three cycles.
module dmem_arbiter #(
    parameter int unsigned DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        dbg_req,
    input  logic        cpu_we,
    input  logic        dbg_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [31:0] dbg_wdata,
    output logic        cpu_ack,
    output logic        dbg_ack,
    output logic [31:0] cpu_rdata,
    output logic [31:0] dbg_rdata,
    output logic        cpu_stall,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [31:0] DepthW = 32'(DEPTH);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q;
    logic        gnt_dbg_q, last_dbg_q, we_q, in_range_q;
    logic        cpu_ack_q, dbg_ack_q, err_q, mem_write_q, mem_read_q;
    logic [31:0] mem_addr_q, mem_wdata_q, cpu_rdata_q, dbg_rdata_q;

    logic        pick_dbg, sel_we, sel_in_range;
    logic [31:0] sel_addr, sel_wdata, access_rdata;

    always_comb begin
        // dbg wins only when alone or when cpu was granted last time
        pick_dbg     = dbg_req & (~cpu_req | ~last_dbg_q);
        sel_we       = pick_dbg ? dbg_we    : cpu_we;
        sel_addr     = pick_dbg ? dbg_addr  : cpu_addr;
        sel_wdata    = pick_dbg ? dbg_wdata : cpu_wdata;
        sel_in_range = sel_addr < DepthW;
        access_rdata = (in_range_q & ~we_q) ? mem_rdata : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            gnt_dbg_q   <= 1'b0;
            last_dbg_q  <= 1'b1;
            we_q        <= 1'b0;
            in_range_q  <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            err_q       <= 1'b0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            cpu_rdata_q <= 32'h0;
            dbg_rdata_q <= 32'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cpu_req | dbg_req) begin
                        gnt_dbg_q   <= pick_dbg;
                        last_dbg_q  <= pick_dbg;
                        we_q        <= sel_we;
                        in_range_q  <= sel_in_range;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        // strobes are registered so they are high for the ACCESS cycle only
                        mem_write_q <= sel_we & sel_in_range;
                        mem_read_q  <= ~sel_we & sel_in_range;
                        state_q     <= StAccess;
                    end
                end
                StAccess: begin
                    mem_write_q <= 1'b0;
                    mem_read_q  <= 1'b0;
                    err_q       <= ~in_range_q;
                    if (gnt_dbg_q) begin
                        dbg_rdata_q <= access_rdata;
                        dbg_ack_q   <= 1'b1;
                    end else begin
                        cpu_rdata_q <= access_rdata;
                        cpu_ack_q   <= 1'b1;
                    end
                    state_q <= StResp;
                end
                StResp: begin
                    cpu_ack_q <= 1'b0;
                    dbg_ack_q <= 1'b0;
                    err_q     <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign err       = err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_write = mem_write_q;
    assign mem_read  = mem_read_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level model of arbitration and memory contents.
module tb_dmem_arbiter;

    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req, dbg_req, cpu_we, dbg_we;
    logic [31:0] cpu_addr, dbg_addr, cpu_wdata, dbg_wdata;
    logic        cpu_ack, dbg_ack, cpu_stall, err, mem_write, mem_read, busy;
    logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] phys [DEPTH];
    int vectors = 0;
    int miscompares = 0;

    dmem_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .dbg_req(dbg_req), .cpu_we(cpu_we), .dbg_we(dbg_we),
        .cpu_addr(cpu_addr), .dbg_addr(dbg_addr), .cpu_wdata(cpu_wdata), .dbg_wdata(dbg_wdata),
        .cpu_ack(cpu_ack), .dbg_ack(dbg_ack), .cpu_rdata(cpu_rdata), .dbg_rdata(dbg_rdata),
        .cpu_stall(cpu_stall), .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-port memory: combinational read, write on the rising edge.
    assign mem_rdata = (mem_addr < 32'(DEPTH)) ? phys[mem_addr[AW-1:0]] : 32'hBAD0_BAD0;
    always @(posedge clk) if (mem_write && mem_addr < 32'(DEPTH)) phys[mem_addr[AW-1:0]] <= mem_wdata;

    task automatic idle_inputs();
        cpu_req = 0; dbg_req = 0; cpu_we = 0; dbg_we = 0;
        cpu_addr = 0; dbg_addr = 0; cpu_wdata = 0; dbg_wdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (cpu_ack !== 1'b0 || dbg_ack !== 1'b0) begin miscompares++;
            $display("FAIL reset_acks: got %b%b want 00", cpu_ack, dbg_ack); end
        vectors++; if (err !== 1'b0 || busy !== 1'b0) begin miscompares++;
            $display("FAIL reset_err_busy: got %b%b want 00", err, busy); end
        vectors++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin miscompares++;
            $display("FAIL reset_strobes: got %b%b want 00", mem_write, mem_read); end
        vectors++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin miscompares++;
            $display("FAIL reset_mem_bus: got %h %h want 0 0", mem_addr, mem_wdata); end
        vectors++; if (cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin miscompares++;
            $display("FAIL reset_rdata: got %h %h want 0 0", cpu_rdata, dbg_rdata); end
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++;
            $display("FAIL post_reset_busy: got %b want 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_read();
        phys[5] <= 32'd110;
        cpu_req = 1; cpu_we = 0; cpu_addr = 5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++; if (mem_read !== (c == 1)) begin miscompares++;
                $display("FAIL rd_mem_read c%0d: got %b want %b", c, mem_read, c == 1); end
            vectors++; if (cpu_stall !== (c < 2)) begin miscompares++;
                $display("FAIL rd_stall c%0d: got %b want %b", c, cpu_stall, c < 2); end
            vectors++; if (cpu_ack !== (c == 2)) begin miscompares++;
                $display("FAIL rd_ack c%0d: got %b want %b", c, cpu_ack, c == 2); end
            if (c == 2) begin
                vectors++; if (cpu_rdata !== 32'd110) begin miscompares++;
                    $display("FAIL rd_data: got %0d want 110", cpu_rdata); end
            end
            @(posedge clk); #1;
        end
        cpu_req = 0;
    endtask

    task automatic test_write_read();
        int wr_pulses = 0;
        int ack_cyc = -1;
        dbg_req = 1; dbg_we = 1; dbg_addr = 3; dbg_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mem_write) wr_pulses++;
            if (dbg_ack && ack_cyc < 0) ack_cyc = c;
            @(posedge clk); #1;
            if (c == 2) dbg_req = 0;
        end
        vectors++; if (wr_pulses != 1) begin miscompares++;
            $display("FAIL wr_pulses: got %0d want 1", wr_pulses); end
        vectors++; if (ack_cyc != 2) begin miscompares++;
            $display("FAIL wr_ack_cycle: got %0d want 2", ack_cyc); end
        vectors++; if (phys[3] !== 32'hDEAD_BEEF) begin miscompares++;
            $display("FAIL wr_mem_word: got %h want deadbeef", phys[3]); end
        cpu_req = 1; cpu_we = 0; cpu_addr = 3; ack_cyc = -1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (cpu_ack && ack_cyc < 0) begin
                ack_cyc = c;
                vectors++; if (cpu_rdata !== 32'hDEAD_BEEF) begin miscompares++;
                    $display("FAIL rdback_data: got %h want deadbeef", cpu_rdata); end
            end
            @(posedge clk); #1;
            if (c == 2) cpu_req = 0;
        end
        vectors++; if (ack_cyc != 2) begin miscompares++;
            $display("FAIL rdback_ack_cycle: got %0d want 2", ack_cyc); end
    endtask

    task automatic test_out_of_range();
        int strobes = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 40;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_read || mem_write) strobes++;
            if (c == 2) begin
                vectors++; if (cpu_ack !== 1'b1 || err !== 1'b1) begin miscompares++;
                    $display("FAIL oor_ack_err: got %b%b want 11", cpu_ack, err); end
                vectors++; if (cpu_rdata !== 32'h0) begin miscompares++;
                    $display("FAIL oor_rdata: got %h want 0", cpu_rdata); end
            end
            @(posedge clk); #1;
        end
        cpu_req = 0;
        vectors++; if (strobes != 0) begin miscompares++;
            $display("FAIL oor_strobes: got %0d want 0", strobes); end
        @(negedge clk);
        vectors++; if (err !== 1'b0) begin miscompares++;
            $display("FAIL oor_err_clear: got %b want 0", err); end
        @(posedge clk); #1;
    endtask

    task automatic test_addr_change();
        cpu_req = 1; cpu_we = 1; cpu_addr = 7; cpu_wdata = 32'hA5A5_A5A5;
        @(negedge clk); @(posedge clk); #1;
        cpu_addr = 9; cpu_wdata = 32'h0BAD_F00D;
        @(negedge clk);
        vectors++; if (mem_addr !== 32'd7 || mem_wdata !== 32'hA5A5_A5A5) begin miscompares++;
            $display("FAIL chg_latched: got %0d %h want 7 a5a5a5a5", mem_addr, mem_wdata); end
        vectors++; if (mem_write !== 1'b1) begin miscompares++;
            $display("FAIL chg_write: got %b want 1", mem_write); end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if (cpu_ack !== 1'b1) begin miscompares++;
            $display("FAIL chg_ack: got %b want 1", cpu_ack); end
        @(posedge clk); #1 cpu_req = 0;
        @(negedge clk);
        vectors++; if (mem_addr !== 32'd7 || mem_write !== 1'b0) begin miscompares++;
            $display("FAIL chg_hold: got %0d %b want 7 0", mem_addr, mem_write); end
        vectors++; if (phys[7] !== 32'hA5A5_A5A5 || phys[9] !== 32'h1009) begin miscompares++;
            $display("FAIL chg_mem: got %h %h want a5a5a5a5 1009", phys[7], phys[9]); end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        int who [4];
        int cyc [4];
        int n = 0;
        int exp_who [4] = '{0, 1, 0, 1};
        int exp_cyc [4] = '{2, 5, 8, 11};
        do_reset();
        phys[1] <= 32'h11; phys[2] <= 32'h22;
        cpu_req = 1; cpu_we = 0; cpu_addr = 1;
        dbg_req = 1; dbg_we = 0; dbg_addr = 2;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            vectors++; if (cpu_ack && dbg_ack) begin miscompares++;
                $display("FAIL rr_coincident c%0d: got 11 want not both", c); end
            if ((cpu_ack || dbg_ack) && n < 4) begin
                who[n] = dbg_ack ? 1 : 0; cyc[n] = c; n++;
                vectors++; if ((cpu_ack && cpu_rdata !== 32'h11) ||
                               (dbg_ack && dbg_rdata !== 32'h22)) begin miscompares++;
                    $display("FAIL rr_data c%0d: got %h %h want 11 22", c, cpu_rdata, dbg_rdata); end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        vectors++; if (n != 4) begin miscompares++;
            $display("FAIL rr_count: got %0d want 4", n); end
        for (int i = 0; i < n; i++) begin
            vectors++; if (who[i] != exp_who[i] || cyc[i] != exp_cyc[i]) begin miscompares++;
                $display("FAIL rr_grant%0d: got port%0d@%0d want port%0d@%0d",
                         i, who[i], cyc[i], exp_who[i], exp_cyc[i]); end
        end
    endtask

    task automatic test_reset_during_access();
        int acks = 0;
        int busies = 0;
        do_reset();
        phys[4] <= 32'h5555;
        dbg_req = 1; dbg_we = 1; dbg_addr = 4; dbg_wdata = 32'h1234;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk);
        vectors++; if (mem_write !== 1'b1) begin miscompares++;
            $display("FAIL rsta_write_before: got %b want 1", mem_write); end
        #1 rst_n = 0;
        #1;
        vectors++; if (mem_write !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL rsta_async: got w%b b%b a%h want w0 b0 a0", mem_write, busy, mem_addr);
        end
        idle_inputs();
        @(posedge clk); #1 rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (dbg_ack || cpu_ack) acks++;
            if (busy || err || mem_write || mem_read) busies++;
            @(posedge clk); #1;
        end
        vectors++; if (acks != 0 || busies != 0) begin miscompares++;
            $display("FAIL rsta_after: got acks %0d active %0d want 0 0", acks, busies); end
        vectors++; if (phys[4] !== 32'h5555 || dbg_rdata !== 32'h0) begin miscompares++;
            $display("FAIL rsta_discard: got %h %h want 5555 0", phys[4], dbg_rdata); end
    endtask

    task automatic test_random();
        logic [31:0] model_mem [DEPTH];
        logic [31:0] rd_m [2];
        bit          pend [2];
        bit          pwe [2];
        logic [31:0] paddr [2];
        logic [31:0] pdata [2];
        int          last_m, g;
        bit          inr;
        logic [31:0] exp_rd;
        do_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = phys[i];
        rd_m[0] = 0; rd_m[1] = 0; pend[0] = 0; pend[1] = 0;
        last_m = 1;
        for (int it = 0; it < 80; it++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p] = 1; pwe[p] = 1'($urandom_range(0, 1));
                    paddr[p] = 32'($urandom_range(0, 39)); pdata[p] = $urandom;
                end
            end
            cpu_req = pend[0]; cpu_we = pwe[0]; cpu_addr = paddr[0]; cpu_wdata = pdata[0];
            dbg_req = pend[1]; dbg_we = pwe[1]; dbg_addr = paddr[1]; dbg_wdata = pdata[1];
            if (!pend[0] && !pend[1]) begin
                @(negedge clk);
                vectors++; if (busy !== 1'b0) begin miscompares++;
                    $display("FAIL rnd_idle_busy it%0d: got %b want 0", it, busy); end
                @(posedge clk); #1;
                continue;
            end
            g = (pend[0] && pend[1]) ? (last_m == 1 ? 0 : 1) : (pend[1] ? 1 : 0);
            last_m = g;
            inr = paddr[g] < 32'(DEPTH);
            exp_rd = (inr && !pwe[g]) ? model_mem[paddr[g][AW-1:0]] : 32'h0;
            if (inr && pwe[g]) model_mem[paddr[g][AW-1:0]] = pdata[g];
            @(negedge clk);
            vectors++; if (busy !== 1'b0 || cpu_stall !== pend[0]) begin miscompares++;
                $display("FAIL rnd_c0 it%0d: got busy%b stall%b want 0 %b",
                         it, busy, cpu_stall, pend[0]); end
            @(posedge clk); #1;
            // Scramble the granted payload and sometimes drop its request mid-flight.
            if (g == 0) begin
                cpu_addr = $urandom; cpu_wdata = $urandom; cpu_we = ~cpu_we;
                if ($urandom_range(0, 3) == 0) cpu_req = 0;
            end else begin
                dbg_addr = $urandom; dbg_wdata = $urandom; dbg_we = ~dbg_we;
                if ($urandom_range(0, 3) == 0) dbg_req = 0;
            end
            @(negedge clk);
            vectors++; if (mem_read !== (inr && !pwe[g]) || mem_write !== (inr && pwe[g]) ||
                           (inr && mem_addr !== paddr[g])) begin miscompares++;
                $display("FAIL rnd_access it%0d: got r%b w%b a%h want r%b w%b a%h", it,
                         mem_read, mem_write, mem_addr, inr && !pwe[g], inr && pwe[g], paddr[g]);
            end
            @(posedge clk); #1;
            @(negedge clk);
            vectors++; if (cpu_ack !== (g == 0) || dbg_ack !== (g == 1) || err !== !inr) begin
                miscompares++;
                $display("FAIL rnd_ack it%0d: got c%b d%b e%b want c%b d%b e%b", it,
                         cpu_ack, dbg_ack, err, g == 0, g == 1, !inr);
            end
            rd_m[g] = exp_rd;
            vectors++; if (cpu_rdata !== rd_m[0] || dbg_rdata !== rd_m[1]) begin miscompares++;
                $display("FAIL rnd_rdata it%0d: got %h %h want %h %h", it,
                         cpu_rdata, dbg_rdata, rd_m[0], rd_m[1]); end
            @(posedge clk); #1;
            pend[g] = 0;
            if (g == 0) cpu_req = 0; else dbg_req = 0;
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) phys[i] <= 32'h1000 + 32'(i);
        idle_inputs();
        test_reset();
        test_cpu_read();
        test_write_read();
        test_out_of_range();
        test_addr_change();
        test_round_robin();
        test_reset_during_access();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
